// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// cache_pkg : shared widths, FSM encodings and address-field helpers
// Revision  : 1.0
// ============================================================================
package cache_pkg;

  localparam int ADDR_W    = 15;
  localparam int WORD_W    = 32;
  localparam int OFFSET_W  = 2;
  localparam int INDEX_W   = 10;
  localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BLOCK_W   = WORD_W << OFFSET_W;
  localparam int LINES     = 1 << INDEX_W;
  localparam int MEM_WORDS = 32000;
  localparam int CNT_W     = 32;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPARE = 2'd1;
  localparam logic [1:0] ST_MISS    = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1:0];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                   input logic [OFFSET_W-1:0] off);
    return blk[off*WORD_W +: WORD_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_line_store.sv
`default_nettype none
// ============================================================================
// cache_line_store : valid/tag/data arrays, one combinational read port and
//                    one fill port; valid bits cleared on reset
// Revision         : 1.0
// ============================================================================
module cache_line_store
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [BLOCK_W-1:0] rd_data_o,
  input  logic               fill_en_i,
  input  logic [INDEX_W-1:0] fill_index_i,
  input  logic [TAG_W-1:0]   fill_tag_i,
  input  logic [BLOCK_W-1:0] fill_data_i
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_index_i] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[fill_index_i]  <= fill_tag_i;
      data_q[fill_index_i] <= fill_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule
`default_nettype wire

// File: rtl/dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// dm_cache_ctrl : read-only direct-mapped cache controller with block refill
//                 from main memory and hit/access counters
// Revision      : 1.0
// ============================================================================
module dm_cache_ctrl
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               req_ready,
  output logic               resp_valid,
  output logic [WORD_W-1:0]  resp_data,
  output logic               resp_hit,
  output logic               resp_err,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [BLOCK_W-1:0] mem_data,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   acc_count
);

  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_WORDS);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                resp_valid_q, resp_valid_d;
  logic [WORD_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_hit_q, resp_hit_d;
  logic                resp_err_q, resp_err_d;
  logic                mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;

  logic                line_valid;
  logic [TAG_W-1:0]    line_tag;
  logic [BLOCK_W-1:0]  line_data;
  logic                fill_en;
  logic                lookup_hit;
  logic                out_of_range;

  cache_line_store u_store (
    .clk          (clk),
    .rst          (rst),
    .rd_index_i   (addr_index(addr_q)),
    .rd_valid_o   (line_valid),
    .rd_tag_o     (line_tag),
    .rd_data_o    (line_data),
    .fill_en_i    (fill_en),
    .fill_index_i (addr_index(addr_q)),
    .fill_tag_i   (addr_tag(addr_q)),
    .fill_data_i  (mem_data)
  );

  assign out_of_range = (addr_q >= MEM_LIMIT);
  assign lookup_hit   = line_valid && (line_tag == addr_tag(addr_q));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_hit_d   = resp_hit_q;
    resp_err_d   = resp_err_q;
    mem_rd_d     = mem_rd_q;
    mem_addr_d   = mem_addr_q;
    hit_cnt_d    = hit_cnt_q;
    acc_cnt_d    = acc_cnt_q;
    fill_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (out_of_range) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = '0;
          resp_hit_d   = 1'b0;
          resp_err_d   = 1'b1;
        end else if (lookup_hit) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = block_word(line_data, addr_offset(addr_q));
          resp_hit_d   = 1'b1;
          resp_err_d   = 1'b0;
          hit_cnt_d    = hit_cnt_q + 1'b1;
          acc_cnt_d    = acc_cnt_q + 1'b1;
        end else begin
          state_d    = ST_MISS;
          mem_rd_d   = 1'b1;
          mem_addr_d = {addr_tag(addr_q), addr_index(addr_q), {OFFSET_W{1'b0}}};
          acc_cnt_d  = acc_cnt_q + 1'b1;
        end
      end
      ST_MISS: begin
        // The returned word comes straight off the memory bus on the fill edge.
        if (mem_ready) begin
          fill_en      = 1'b1;
          mem_rd_d     = 1'b0;
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = block_word(mem_data, addr_offset(addr_q));
          resp_hit_d   = 1'b0;
          resp_err_d   = 1'b0;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_hit_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      hit_cnt_q    <= '0;
      acc_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_hit_q   <= resp_hit_d;
      resp_err_q   <= resp_err_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      hit_cnt_q    <= hit_cnt_d;
      acc_cnt_q    <= acc_cnt_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_hit   = resp_hit_q;
  assign resp_err   = resp_err_q;
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign hit_count  = hit_cnt_q;
  assign acc_count  = acc_cnt_q;

endmodule
`default_nettype wire
